// File: rtl/libnet_pkg.sv
// Shared libnet definitions: TCP header field offsets inside a 512-bit beat
// and the transmit arbiter state encoding (also used by the receive path).
package libnet_pkg;

  localparam int SEQ_LSB      = 344;
  localparam int SEQ_MSB      = 375;
  localparam int ACK_FLAG_BIT = 376;
  localparam int SYN_FLAG_BIT = 377;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_APP  = 2'd1,
    ST_ACK  = 2'd2
  } tx_state_e;

  typedef enum logic {
    GRANT_APP = 1'b0,
    GRANT_ACK = 1'b1
  } grant_e;

endpackage

// File: rtl/libnet_tx_arbiter_512.sv
// Shares the sysnet transmit port between application packets and generated
// single-beat ack packets, switching only on packet boundaries.
module libnet_tx_arbiter_512
  import libnet_pkg::*;
#(
  parameter int          CURRENT_SEQ_LSB = SEQ_LSB,
  parameter int          CURRENT_SEQ_MSB = SEQ_MSB,
  parameter int          ACK_FLAG        = ACK_FLAG_BIT,
  parameter int          SYN_FLAG        = SYN_FLAG_BIT,
  parameter logic [63:0] ACK_TKEEP       = 64'h0000_FFFF_FFFF_FFFF
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [31:0]  seq_expected,
  input  logic         seq_valid,
  input  logic [511:0] app_tdata,
  input  logic [63:0]  app_tkeep,
  input  logic [63:0]  app_tuser,
  input  logic         app_tvalid,
  input  logic         app_tlast,
  output logic         app_tready,
  output logic [511:0] tx_tdata,
  output logic [63:0]  tx_tkeep,
  output logic [63:0]  tx_tuser,
  output logic         tx_tvalid,
  output logic         tx_tlast,
  input  logic         tx_tready,
  output logic [31:0]  acks_sent,
  output logic [31:0]  acks_coalesced
);

  tx_state_e    state_reg, state_next;
  grant_e       last_grant_reg, last_grant_next;
  logic         ack_pending_reg;
  logic [31:0]  ack_seq_reg;
  logic         tx_free;
  logic         ack_load;
  logic         app_hs;
  logic         ack_hs;
  logic [511:0] ack_tdata;

  assign tx_free    = !tx_tvalid || tx_tready;
  assign app_tready = (state_reg == ST_APP) && tx_free;
  assign app_hs     = app_tvalid && app_tready;
  assign ack_hs     = (state_reg == ST_ACK) && tx_tvalid && tx_tready;

  always_comb begin
    ack_tdata = '0;
    ack_tdata[CURRENT_SEQ_MSB:CURRENT_SEQ_LSB] = ack_seq_reg;
    ack_tdata[ACK_FLAG] = 1'b1;
    ack_tdata[SYN_FLAG] = 1'b0;
  end

  // Round-robin only matters on a tie; the loser of the last grant goes first.
  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    ack_load        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (tx_free) begin
          if (ack_pending_reg && (!app_tvalid || last_grant_reg == GRANT_APP)) begin
            ack_load        = 1'b1;
            state_next      = ST_ACK;
            last_grant_next = GRANT_ACK;
          end else if (app_tvalid) begin
            state_next      = ST_APP;
            last_grant_next = GRANT_APP;
          end
        end
      end
      ST_APP: begin
        if (app_hs && app_tlast) state_next = ST_IDLE;
      end
      ST_ACK: begin
        if (ack_hs) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= ST_IDLE;
      last_grant_reg <= GRANT_APP;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
    end
  end

  // A new ack arriving on the load cycle re-arms pending rather than coalescing.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ack_pending_reg <= 1'b0;
      ack_seq_reg     <= '0;
      acks_coalesced  <= '0;
    end else if (seq_valid) begin
      ack_pending_reg <= 1'b1;
      ack_seq_reg     <= seq_expected;
      if (ack_pending_reg && !ack_load) acks_coalesced <= acks_coalesced + 32'd1;
    end else if (ack_load) begin
      ack_pending_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acks_sent <= '0;
    end else if (ack_hs) begin
      acks_sent <= acks_sent + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_tdata  <= '0;
      tx_tkeep  <= '0;
      tx_tuser  <= '0;
      tx_tlast  <= 1'b0;
      tx_tvalid <= 1'b0;
    end else if (ack_load) begin
      tx_tdata  <= ack_tdata;
      tx_tkeep  <= ACK_TKEEP;
      tx_tuser  <= '0;
      tx_tlast  <= 1'b1;
      tx_tvalid <= 1'b1;
    end else if (app_hs) begin
      tx_tdata  <= app_tdata;
      tx_tkeep  <= app_tkeep;
      tx_tuser  <= app_tuser;
      tx_tlast  <= app_tlast;
      tx_tvalid <= 1'b1;
    end else if (tx_tready) begin
      tx_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_libnet_tx_arbiter_512.sv
// Scoreboard bench for libnet_tx_arbiter_512: ack/app expectations are queued
// as stimulus is driven and popped as beats leave the transmit port.
module tb_libnet_tx_arbiter_512;

  typedef struct {
    logic [511:0] data;
    logic [63:0]  keep;
    logic [63:0]  user;
    logic         last;
  } beat_t;

  typedef struct {
    logic [31:0] seq;
    int          sent;
  } ack_vec_t;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic [31:0]  seq_expected = '0;
  logic         seq_valid = 1'b0;
  logic [511:0] app_tdata = '0;
  logic [63:0]  app_tkeep = '0;
  logic [63:0]  app_tuser = '0;
  logic         app_tvalid = 1'b0;
  logic         app_tlast = 1'b0;
  logic         app_tready;
  logic [511:0] tx_tdata;
  logic [63:0]  tx_tkeep;
  logic [63:0]  tx_tuser;
  logic         tx_tvalid;
  logic         tx_tlast;
  logic         tx_tready = 1'b1;
  logic [31:0]  acks_sent;
  logic [31:0]  acks_coalesced;

  beat_t       app_q[$];
  logic [31:0] ack_q[$];
  bit          kind_q[$];
  int          checks = 0;
  int          errors = 0;
  int          acks_pushed = 0;
  ack_vec_t    vec[4];

  libnet_tx_arbiter_512 dut (
    .clk(clk), .resetn(resetn),
    .seq_expected(seq_expected), .seq_valid(seq_valid),
    .app_tdata(app_tdata), .app_tkeep(app_tkeep), .app_tuser(app_tuser),
    .app_tvalid(app_tvalid), .app_tlast(app_tlast), .app_tready(app_tready),
    .tx_tdata(tx_tdata), .tx_tkeep(tx_tkeep), .tx_tuser(tx_tuser),
    .tx_tvalid(tx_tvalid), .tx_tlast(tx_tlast), .tx_tready(tx_tready),
    .acks_sent(acks_sent), .acks_coalesced(acks_coalesced)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] ack_beat(input logic [31:0] s);
    logic [511:0] d;
    d = '0;
    d[375:344] = s;
    d[376] = 1'b1;
    return d;
  endfunction

  function automatic beat_t mk_beat(input int pkt, input int b, input bit last);
    beat_t r;
    r.data = {16{32'hA500_0000 | 32'(pkt * 16 + b)}};
    r.keep = 64'hFFFF_FFFF_FFFF_FFFF >> b;
    r.user = {32'(pkt + 1), 32'(b + 1)};
    r.last = last;
    return r;
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic pulse_seq(input logic [31:0] v);
    seq_valid = 1'b1;
    seq_expected = v;
    ack_q.push_back(v);
    acks_pushed++;
    @(posedge clk); #1;
    seq_valid = 1'b0;
  endtask

  task automatic send_app(input int nbeats, input int pkt, input int ack_at, input logic [31:0] ack_val);
    beat_t bt;
    int n;
    for (int b = 0; b < nbeats; b++) begin
      bt = mk_beat(pkt, b, b == nbeats - 1);
      app_tdata = bt.data; app_tkeep = bt.keep; app_tuser = bt.user;
      app_tlast = bt.last; app_tvalid = 1'b1;
      if (b == ack_at) begin
        seq_valid = 1'b1; seq_expected = ack_val;
        ack_q.push_back(ack_val); acks_pushed++;
      end
      n = 0;
      forever begin
        @(negedge clk);
        if (app_tready || n >= 200) break;
        n++;
        @(posedge clk); #1;
        seq_valid = 1'b0;
      end
      if (!app_tready) begin
        checks++; errors++;
        $display("FAIL app_tready_timeout actual=0 required=1 pkt=%0d beat=%0d", pkt, b);
      end else begin
        app_q.push_back(bt);
      end
      @(posedge clk); #1;
      seq_valid = 1'b0;
    end
    app_tvalid = 1'b0;
    app_tlast = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((ack_q.size() != 0 || app_q.size() != 0 || tx_tvalid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL %s_drain actual=acks_left %0d beats_left %0d required=0", name, ack_q.size(), app_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic check_kinds(input string name, input int n, input logic [7:0] pat);
    logic [7:0] act = '0;
    bit ok;
    ok = (kind_q.size() == n);
    for (int i = 0; i < kind_q.size() && i < 8; i++) act[i] = kind_q[i];
    if (ok) for (int i = 0; i < n; i++) if (act[i] != pat[i]) ok = 0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_order actual=%0d pkts pattern %b required=%0d pkts pattern %b", name, kind_q.size(), act, n, pat);
    end
    kind_q.delete();
  endtask

  // Output monitor: handshake at the next rising edge is decided by what is seen here.
  initial begin : monitor
    logic  stall_prev;
    beat_t held;
    beat_t e;
    logic [31:0] s;
    stall_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        stall_prev = 1'b0;
        continue;
      end
      if (stall_prev) begin
        checks++;
        if (tx_tvalid !== 1'b1 || tx_tdata !== held.data || tx_tkeep !== held.keep ||
            tx_tuser !== held.user || tx_tlast !== held.last) begin
          errors++;
          $display("FAIL stall_hold actual=valid %b user %0h required=valid 1 user %0h", tx_tvalid, tx_tuser, held.user);
        end
      end
      if (tx_tvalid && tx_tready) begin
        checks++;
        if (tx_tuser == 64'd0) begin
          if (ack_q.size() == 0) begin
            errors++;
            $display("FAIL ack_beat actual=unexpected seq %0h required=no ack", tx_tdata[375:344]);
          end else begin
            s = ack_q.pop_front();
            if (tx_tdata !== ack_beat(s) || tx_tkeep !== 64'h0000_FFFF_FFFF_FFFF || tx_tlast !== 1'b1) begin
              errors++;
              $display("FAIL ack_beat actual=seq %0h ack %b syn %b last %b keep %0h required=seq %0h ack 1 syn 0 last 1 keep ffffffffffff",
                       tx_tdata[375:344], tx_tdata[376], tx_tdata[377], tx_tlast, tx_tkeep, s);
            end
          end
        end else begin
          if (app_q.size() == 0) begin
            errors++;
            $display("FAIL app_beat actual=unexpected user %0h required=no beat", tx_tuser);
          end else begin
            e = app_q.pop_front();
            if (tx_tdata !== e.data || tx_tkeep !== e.keep || tx_tuser !== e.user || tx_tlast !== e.last) begin
              errors++;
              $display("FAIL app_beat actual=user %0h keep %0h last %b required=user %0h keep %0h last %b",
                       tx_tuser, tx_tkeep, tx_tlast, e.user, e.keep, e.last);
            end
          end
        end
        if (tx_tlast) kind_q.push_back(tx_tuser == 64'd0);
      end
      stall_prev = tx_tvalid && !tx_tready;
      held.data = tx_tdata; held.keep = tx_tkeep; held.user = tx_tuser; held.last = tx_tlast;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    beat_t bt;
    logic [7:0] rdy_pat;
    int n;

    vec[0] = '{32'h0000_0005, 1};
    vec[1] = '{32'h0000_0000, 2};
    vec[2] = '{32'hFFFF_FFFF, 3};
    vec[3] = '{32'hA5A5_5A5A, 4};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_tvalid", 512'(tx_tvalid), 512'(1'b0));
    chk("rst_tlast", 512'(tx_tlast), 512'(1'b0));
    chk("rst_app_tready", 512'(app_tready), 512'(1'b0));
    chk("rst_tdata", tx_tdata, 512'd0);
    chk("rst_tkeep_tuser", 512'({tx_tkeep, tx_tuser}), 512'd0);
    chk("rst_counters", 512'({acks_sent, acks_coalesced}), 512'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Single acks from the table, including the two-cycle latency.
    for (int i = 0; i < 4; i++) begin
      seq_valid = 1'b1;
      seq_expected = vec[i].seq;
      ack_q.push_back(vec[i].seq);
      acks_pushed++;
      @(posedge clk); #1;
      seq_valid = 1'b0;
      chk("ack_latency_n1", 512'(tx_tvalid), 512'(1'b0));
      @(posedge clk); #1;
      chk("ack_latency_n2", 512'(tx_tvalid), 512'(1'b1));
      wait_drain("single_ack");
      chk("acks_sent_single", 512'(acks_sent), 512'(32'(vec[i].sent)));
      check_kinds("single_ack", 1, 8'h01);
    end

    // Coalescing: 7 loads, 8 re-arms on the load cycle, 9 coalesces over 8.
    tx_tready = 1'b0;
    seq_valid = 1'b1; seq_expected = 32'd7;
    ack_q.push_back(32'd7); acks_pushed++;
    @(posedge clk); #1;
    seq_expected = 32'd8;
    @(posedge clk); #1;
    seq_expected = 32'd9;
    ack_q.push_back(32'd9); acks_pushed++;
    @(posedge clk); #1;
    seq_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("coalesce_count", 512'(acks_coalesced), 512'(32'd1));
    chk("coalesce_stalled_valid", 512'(tx_tvalid), 512'(1'b1));
    tx_tready = 1'b1;
    wait_drain("coalesce");
    chk("acks_sent_coalesce", 512'(acks_sent), 512'(32'(acks_pushed)));
    check_kinds("coalesce", 2, 8'h03);

    // Round-robin: back-to-back 3-beat packets, an ack raised during each.
    for (int p = 0; p < 3; p++) send_app(3, p, 1, 32'h100 + 32'(p));
    wait_drain("round_robin");
    check_kinds("round_robin", 6, 8'h2A);
    chk("acks_sent_rr", 512'(acks_sent), 512'(32'(acks_pushed)));

    // Tie right after an ack grant: the application goes first.
    tx_tready = 1'b0;
    pulse_seq(32'h200);
    @(posedge clk); #1;
    seq_valid = 1'b1; seq_expected = 32'h201;
    ack_q.push_back(32'h201); acks_pushed++;
    @(posedge clk); #1;
    seq_valid = 1'b0;
    tx_tready = 1'b1;
    send_app(2, 10, -1, 32'd0);
    wait_drain("tie");
    check_kinds("tie", 3, 8'h05);

    // No preemption: ack raised during beat 2 of a 4-beat packet.
    send_app(4, 20, 1, 32'h300);
    wait_drain("no_preempt");
    check_kinds("no_preempt", 2, 8'h02);

    // Backpressure pattern 1,0,0,1 (twice) during a 5-beat packet.
    rdy_pat = 8'b1001_1001;
    fork
      send_app(5, 30, -1, 32'd0);
      begin
        for (int i = 0; i < 8; i++) begin
          tx_tready = rdy_pat[i];
          @(posedge clk); #1;
        end
        tx_tready = 1'b1;
      end
    join
    wait_drain("backpressure");
    check_kinds("backpressure", 1, 8'h00);
    chk("acks_sent_before_reset", 512'(acks_sent), 512'(32'(acks_pushed)));

    // Reset in the middle of an application packet.
    bt = mk_beat(40, 0, 1'b0);
    app_tdata = bt.data; app_tkeep = bt.keep; app_tuser = bt.user;
    app_tlast = 1'b0; app_tvalid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (app_tready || n >= 20) break;
      n++;
    end
    chk("mid_pkt_ready", 512'(app_tready), 512'(1'b1));
    if (app_tready) app_q.push_back(bt);
    @(posedge clk); #1;
    bt = mk_beat(40, 1, 1'b0);
    app_tdata = bt.data; app_tkeep = bt.keep; app_tuser = bt.user;
    @(negedge clk); #2;
    resetn = 1'b0;
    #1;
    chk("mid_rst_tvalid", 512'(tx_tvalid), 512'(1'b0));
    chk("mid_rst_tlast_ready", 512'({tx_tlast, app_tready}), 512'd0);
    chk("mid_rst_tdata", tx_tdata, 512'd0);
    chk("mid_rst_counters", 512'({acks_sent, acks_coalesced}), 512'd0);
    app_tvalid = 1'b0;
    acks_pushed = 0;
    kind_q.delete();
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    pulse_seq(32'hBEEF_0001);
    wait_drain("post_reset");
    chk("acks_sent_post_reset", 512'(acks_sent), 512'(32'(acks_pushed)));
    check_kinds("post_reset", 1, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
